// File: rtl/cdb_slot_scheduler_if.sv
// Issue-queue / CDB-mux handshake bundle for cdb_slot_scheduler.
// The master side is the issue queues plus the CDB mux; the slave side is the scheduler.
interface cdb_slot_scheduler_if;
   logic       ready_int;
   logic       ready_mem;
   logic       ready_mult;
   logic       ready_div;
   logic       div_busy;
   logic       issue_int;
   logic       issue_mem;
   logic       issue_mult;
   logic       issue_div;
   logic [1:0] cdb_owner;
   logic       cdb_owner_valid;

   modport master (
      output ready_int, ready_mem, ready_mult, ready_div, div_busy,
      input  issue_int, issue_mem, issue_mult, issue_div,
      input  cdb_owner, cdb_owner_valid
   );

   modport slave (
      input  ready_int, ready_mem, ready_mult, ready_div, div_busy,
      output issue_int, issue_mem, issue_mult, issue_div,
      output cdb_owner, cdb_owner_valid
   );
endinterface

// File: rtl/cdb_slot_scheduler.sv
// Issue scheduler that reserves future CDB cycles in one shift register so results never collide.
// Optional stall counter is enabled with `define ISSUE_PERF_CNT_EN.
module cdb_slot_scheduler #(
   parameter int unsigned MULT_LAT = 4,
   parameter int unsigned DIV_LAT  = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   cdb_slot_scheduler_if.slave  sched,
   output logic [DIV_LAT-1:0]   slot_map,
   output logic [15:0]          stall_cnt
);

   localparam int unsigned CNT_W = 4;
   localparam logic [1:0]  OWN_INT  = 2'd0;
   localparam logic [1:0]  OWN_MEM  = 2'd1;
   localparam logic [1:0]  OWN_MULT = 2'd2;
   localparam logic [1:0]  OWN_DIV  = 2'd3;

   typedef struct packed {
      logic       valid;
      logic [1:0] owner;
   } res_t;

   res_t             res_q [DIV_LAT];
   res_t             res_d [DIV_LAT];
   logic             rr_q;
   logic             rr_d;
   logic [CNT_W-1:0] div_cnt_q;
   logic [CNT_W-1:0] div_cnt_d;
   logic             lat1_free;
   logic             gnt_int;
   logic             gnt_mem;
   logic             gnt_mult;
   logic             gnt_div;

   // Grants: rr breaks the int/mem tie; every grant is suppressed during reset.
   always_comb begin
      lat1_free = !res_q[1].valid;
      gnt_int   = !rst && lat1_free && sched.ready_int &&
                  (!sched.ready_mem || !rr_q);
      gnt_mem   = !rst && lat1_free && sched.ready_mem &&
                  (!sched.ready_int || rr_q);
      gnt_mult  = !rst && sched.ready_mult && !res_q[MULT_LAT].valid;
      gnt_div   = !rst && sched.ready_div && !sched.div_busy &&
                  (div_cnt_q == '0);
   end

   assign sched.issue_int  = gnt_int;
   assign sched.issue_mem  = gnt_mem;
   assign sched.issue_mult = gnt_mult;
   assign sched.issue_div  = gnt_div;

   // Shift reservations one slot toward the bus, then book the slots for this cycle's grants.
   always_comb begin
      for (int unsigned k = 0; k < DIV_LAT - 1; k++) begin
         res_d[k] = res_q[k+1];
      end
      res_d[DIV_LAT-1] = '0;
      if (gnt_int) begin
         res_d[0] = res_t'{valid: 1'b1, owner: OWN_INT};
      end else if (gnt_mem) begin
         res_d[0] = res_t'{valid: 1'b1, owner: OWN_MEM};
      end
      if (gnt_mult) begin
         res_d[MULT_LAT-1] = res_t'{valid: 1'b1, owner: OWN_MULT};
      end
      if (gnt_div) begin
         res_d[DIV_LAT-1] = res_t'{valid: 1'b1, owner: OWN_DIV};
      end

      rr_d = rr_q;
      if (gnt_int) begin
         rr_d = 1'b1;
      end else if (gnt_mem) begin
         rr_d = 1'b0;
      end

      // div_cnt covers the gap before the divider raises div_busy.
      div_cnt_d = div_cnt_q;
      if (gnt_div) begin
         div_cnt_d = CNT_W'(DIV_LAT - 1);
      end else if (div_cnt_q != '0) begin
         div_cnt_d = div_cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < DIV_LAT; k++) begin
            res_q[k] <= '0;
         end
         rr_q      <= 1'b0;
         div_cnt_q <= '0;
      end else begin
         for (int unsigned k = 0; k < DIV_LAT; k++) begin
            res_q[k] <= res_d[k];
         end
         rr_q      <= rr_d;
         div_cnt_q <= div_cnt_d;
      end
   end

   assign sched.cdb_owner       = res_q[0].owner;
   assign sched.cdb_owner_valid = res_q[0].valid;

   always_comb begin
      for (int unsigned k = 0; k < DIV_LAT; k++) begin
         slot_map[k] = res_q[k].valid;
      end
   end

`ifdef ISSUE_PERF_CNT_EN
   logic        any_ready;
   logic        any_issue;
   logic [15:0] stall_q;

   assign any_ready = sched.ready_int | sched.ready_mem | sched.ready_mult | sched.ready_div;
   assign any_issue = gnt_int | gnt_mem | gnt_mult | gnt_div;

   // Saturating count of cycles where work was waiting but nothing issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if (any_ready && !any_issue && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cdb_slot_scheduler.sv
// Directed, table-driven bench for cdb_slot_scheduler at MULT_LAT=4, DIV_LAT=7.
module tb_cdb_slot_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  slot_map;
   logic [15:0] stall_cnt;

   always #5 clk = ~clk;

   cdb_slot_scheduler_if bus();

   cdb_slot_scheduler #(.MULT_LAT(4), .DIV_LAT(7)) dut (
      .clk       (clk),
      .rst       (rst),
      .sched     (bus),
      .slot_map  (slot_map),
      .stall_cnt (stall_cnt)
   );

`ifdef ISSUE_PERF_CNT_EN
   localparam logic [15:0] STALL3 = 16'd3;
`else
   localparam logic [15:0] STALL3 = 16'd0;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   // rdy/iss bit order: {int, mem, mult, div}
   typedef struct {
      logic [3:0] rdy;
      logic       busy;
      logic [3:0] iss;
      logic       vld;
      logic [1:0] own;
      logic [6:0] map;
   } vec_t;

   vec_t vecs[$];

   task automatic v(input logic [3:0] r, input logic b, input logic [3:0] i,
                    input logic vl, input logic [1:0] o, input logic [6:0] m);
      vec_t e;
      e.rdy = r; e.busy = b; e.iss = i; e.vld = vl; e.own = o; e.map = m;
      vecs.push_back(e);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] r, input logic b);
      bus.ready_int  = r[3];
      bus.ready_mem  = r[2];
      bus.ready_mult = r[1];
      bus.ready_div  = r[0];
      bus.div_busy   = b;
   endtask

   function automatic logic [3:0] iss_now();
      return {bus.issue_int, bus.issue_mem, bus.issue_mult, bus.issue_div};
   endfunction

   initial begin
      // cycle-by-cycle from reset release
      v(4'b0000, 0, 4'b0000, 0, 0, 7'h00);  // c0
      v(4'b0000, 0, 4'b0000, 0, 0, 7'h00);
      v(4'b1000, 0, 4'b1000, 0, 0, 7'h00);  // c2 int pulse
      v(4'b0000, 0, 4'b0000, 1, 0, 7'h01);
      v(4'b0000, 0, 4'b0000, 0, 0, 7'h00);
      v(4'b1100, 0, 4'b0100, 0, 0, 7'h00);  // c5 rr=1 after int: mem first
      v(4'b1100, 0, 4'b1000, 1, 1, 7'h01);
      v(4'b1100, 0, 4'b0100, 1, 0, 7'h01);
      v(4'b1100, 0, 4'b1000, 1, 1, 7'h01);
      v(4'b0000, 0, 4'b0000, 1, 0, 7'h01);
      v(4'b0000, 0, 4'b0000, 0, 0, 7'h00);  // c10
      v(4'b0001, 0, 4'b0001, 0, 0, 7'h00);  // c11 div t=0
      v(4'b0000, 0, 4'b0000, 0, 0, 7'h40);
      v(4'b0000, 0, 4'b0000, 0, 0, 7'h20);
      v(4'b0010, 0, 4'b0000, 0, 0, 7'h10);  // t=3 mult refused
      v(4'b0010, 0, 4'b0010, 0, 0, 7'h08);  // t=4 mult issues
      v(4'b0000, 0, 4'b0000, 0, 0, 7'h0C);
      v(4'b0000, 0, 4'b0000, 0, 0, 7'h06);
      v(4'b0000, 0, 4'b0000, 1, 3, 7'h03);  // t=7 div on CDB
      v(4'b0000, 0, 4'b0000, 1, 2, 7'h01);  // t=8 mult on CDB
      v(4'b0000, 0, 4'b0000, 0, 0, 7'h00);  // c20
      v(4'b0001, 0, 4'b0001, 0, 0, 7'h00);  // c21 div held high
      v(4'b0001, 0, 4'b0000, 0, 0, 7'h40);
      v(4'b0001, 0, 4'b0000, 0, 0, 7'h20);
      v(4'b0001, 0, 4'b0000, 0, 0, 7'h10);
      v(4'b0001, 0, 4'b0000, 0, 0, 7'h08);
      v(4'b0001, 0, 4'b0000, 0, 0, 7'h04);
      v(4'b0001, 0, 4'b0000, 0, 0, 7'h02);
      v(4'b0001, 0, 4'b0001, 1, 3, 7'h01);  // c28 t=7 div again
      v(4'b1010, 0, 4'b1010, 0, 0, 7'h40);  // int + mult same cycle
      v(4'b0000, 0, 4'b0000, 1, 0, 7'h29);  // c30
      v(4'b1110, 0, 4'b0100, 0, 0, 7'h14);  // mem by rr, mult blocked by div
      v(4'b1000, 0, 4'b0000, 1, 1, 7'h0B);  // RES[1] held by mult
      v(4'b1000, 0, 4'b1000, 1, 2, 7'h05);
      v(4'b0000, 0, 4'b0000, 1, 0, 7'h03);
      v(4'b0000, 0, 4'b0000, 1, 3, 7'h01);
      v(4'b0001, 1, 4'b0000, 0, 0, 7'h00);  // div_busy blocks
      v(4'b0001, 0, 4'b0001, 0, 0, 7'h00);
      v(4'b0000, 0, 4'b0000, 0, 0, 7'h40);  // c38

      // reset state, with a ready input that must not be granted
      rst = 1'b1;
      drive(4'b1000, 1'b0);
      @(negedge clk);
      chk("rst_issue", -1, 32'(iss_now()), 32'h0);
      chk("rst_valid", -1, 32'(bus.cdb_owner_valid), 32'h0);
      chk("rst_owner", -1, 32'(bus.cdb_owner), 32'h0);
      chk("rst_map",   -1, 32'(slot_map), 32'h0);
      chk("rst_stall", -1, 32'(stall_cnt), 32'h0);
      drive(4'b0000, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].rdy, vecs[i].busy);
         @(negedge clk);
         chk("issue", i, 32'(iss_now()), 32'(vecs[i].iss));
         chk("valid", i, 32'(bus.cdb_owner_valid), 32'(vecs[i].vld));
         chk("owner", i, 32'(bus.cdb_owner), 32'(vecs[i].own));
         chk("map",   i, 32'(slot_map), 32'(vecs[i].map));
         @(posedge clk);
         #1;
      end

      // three reservations in flight, then an asynchronous reset mid-cycle
      drive(4'b1011, 1'b0);
      @(negedge clk);
      chk("pre_issue", 100, 32'(iss_now()), 32'hA);
      @(posedge clk);
      #1 drive(4'b0000, 1'b0);
      @(negedge clk);
      chk("pre_map",   101, 32'(slot_map), 32'h19);
      chk("pre_valid", 101, 32'(bus.cdb_owner_valid), 32'h1);
      #2 rst = 1'b1;
      drive(4'b1000, 1'b0);
      #1;
      chk("arst_map",   102, 32'(slot_map), 32'h0);
      chk("arst_valid", 102, 32'(bus.cdb_owner_valid), 32'h0);
      chk("arst_issue", 102, 32'(iss_now()), 32'h0);
      @(posedge clk);
      #1 drive(4'b0000, 1'b0);
      @(negedge clk);
      #2 rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("post_valid", 110 + c, 32'(bus.cdb_owner_valid), 32'h0);
         chk("post_map",   110 + c, 32'(slot_map), 32'h0);
      end
      chk("post_stall", 120, 32'(stall_cnt), 32'h0);

      // three stall cycles, then int/mem from a fresh rr
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1 drive(4'b0001, 1'b1);
         @(negedge clk);
         chk("stall_issue", 130 + c, 32'(iss_now()), 32'h0);
      end
      @(posedge clk);
      #1 drive(4'b1100, 1'b0);
      @(negedge clk);
      chk("stall_cnt", 140, 32'(stall_cnt), 32'(STALL3));
      chk("rr_first",  140, 32'(iss_now()), 32'h8);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rr_second", 141, 32'(iss_now()), 32'h4);
      @(posedge clk);
      #1 drive(4'b0000, 1'b0);
      @(negedge clk);
      chk("stall_hold", 142, 32'(stall_cnt), 32'(STALL3));
      chk("rr_owner",   142, 32'(bus.cdb_owner), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
